alu_stream_master: RTL and testbench

Stimulus and collection master for the `axi_alu` datapath. It sits at the opposite end of both of that block's streams:
- It sources operand words on the `r` channel, driving `rvalid`/`rdata` and accepting `rready`.
- It sinks result words on the `w` channel, accepting `wvalid`/`wdata` and driving `wready`.

Operands come from a seeded LFSR. Results are buffered in a small FIFO, counted and XOR-checksummed, then forwarded to a downstream consumer.

---
 rtl/alu_stream_master.sv | 136 +++++++++++++
 tb/tb_alu_stream_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stream_master.sv
// Operand source and result sink for the axi_alu datapath.
// LFSR operands go out on r; results come in on w, are counted, checksummed and queued.
module alu_stream_master #(
    parameter int                DATA_W     = 10,
    parameter int                NUM_OPS    = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] LFSR_SEED  = 10'h2A5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           rvalid,
    output logic [DATA_W-1:0]              rdata,
    input  logic                           rready,
    input  logic                           wvalid,
    input  logic [DATA_W-1:0]              wdata,
    output logic                           wready,
    output logic                           res_valid,
    output logic [DATA_W-1:0]              res_data,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_OPS+1)-1:0]   sent_cnt,
    output logic [$clog2(NUM_OPS+1)-1:0]   recv_cnt,
    output logic [DATA_W-1:0]              checksum
);

    localparam int CW = $clog2(NUM_OPS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(NUM_OPS);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   lfsr;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [AW:0]         occ;
    logic                push;
    logic                pop;
    logic                xfer;

    // x^10 + x^7 + 1 for the default width
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] q);
        return {q[DATA_W-2:0], q[DATA_W-1] ^ q[DATA_W-4]};
    endfunction

    // Every output is a decode of registered state, so no input reaches an output.
    assign busy      = (state == S_SEND) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign rvalid    = (state == S_SEND) && (sent_cnt < LAST);
    assign rdata     = rvalid ? lfsr : '0;
    assign wready    = busy && (occ != FULL) && (recv_cnt < LAST);
    assign res_valid = (occ != '0);
    assign res_data  = res_valid ? mem[rptr] : '0;

    assign xfer = rvalid && rready;
    assign push = wvalid && wready;
    assign pop  = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            lfsr     <= LFSR_SEED;
            sent_cnt <= '0;
            recv_cnt <= '0;
            checksum <= '0;
            wptr     <= '0;
            rptr     <= '0;
            occ      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr     <= LFSR_SEED;
                        sent_cnt <= '0;
                        recv_cnt <= '0;
                        checksum <= '0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sent_cnt == LAST) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (recv_cnt == LAST && occ == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (xfer) begin
                lfsr     <= lfsr_next(lfsr);
                sent_cnt <= sent_cnt + 1'b1;
            end

            if (push) begin
                wptr     <= wptr + 1'b1;
                recv_cnt <= recv_cnt + 1'b1;
                checksum <= checksum ^ wdata;
            end

            if (pop) begin
                rptr <= rptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stream_master.sv
// Randomized bench for alu_stream_master with a loopback ALU and a queue-based
// reference model of the run phases, operand sequence and result FIFO.
module tb_alu_stream_master;

    localparam int W = 10;
    localparam int N = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         rvalid;
    logic [W-1:0] rdata;
    logic         rready = 1'b0;
    logic         wvalid = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         wready;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_ready = 1'b0;
    logic         busy;
    logic         done;
    logic [3:0]   sent_cnt;
    logic [3:0]   recv_cnt;
    logic [W-1:0] checksum;

    int total = 0;
    int bad = 0;

    alu_stream_master #(
        .DATA_W    (W),
        .NUM_OPS   (N),
        .FIFO_DEPTH(D),
        .LFSR_SEED (10'h2A5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rready   (rready),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .wready   (wready),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_ready(res_ready),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt),
        .recv_cnt (recv_cnt),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ops [N];
    logic [W-1:0] mq [$];
    logic [W-1:0] alu_q [$];
    int           ph;
    int           ns;
    int           nr;
    logic [W-1:0] csum;
    int           ndone = 0;
    int           rr_mode = 0;
    int           rs_hold = 0;
    int           k = 0;
    bit           rs_rand = 0;
    bit           wv_rand = 0;
    bit           force_w = 0;
    bit           start_req = 0;
    bit           rst_req = 0;
    bit           first_pending = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] step(input logic [W-1:0] q);
        return {q[8:0], q[9] ^ q[6]};
    endfunction

    function automatic void mreset();
        ph = 0;
        ns = 0;
        nr = 0;
        csum = '0;
        mq.delete();
        alu_q.delete();
    endfunction

    // Drive inputs just after a rising edge, check and advance the model at the falling edge.
    task automatic cycle();
        bit           erv;
        bit           ewr;
        bit           tx;
        bit           push;
        bit           pop;
        int           nph;
        logic [W-1:0] er;
        reset = !rst_req;
        start = start_req;
        if (rr_mode == 0) rready = 1'b1;
        else if (rr_mode == 1) rready = (k % 3 == 0);
        else rready = 1'($urandom % 2);
        k++;
        if (rs_hold > 0) begin
            res_ready = 1'b0;
            rs_hold--;
        end else begin
            res_ready = rs_rand ? 1'($urandom % 2) : 1'b1;
        end
        if (force_w) begin
            wvalid = 1'b1;
            wdata  = W'($urandom);
        end else if (alu_q.size() > 0 && (!wv_rand || $urandom % 4 != 0)) begin
            wvalid = 1'b1;
            wdata  = alu_q[0];
        end else begin
            wvalid = 1'b0;
            wdata  = '0;
        end
        @(negedge clk);
        erv = (ph == 1) && (ns < N);
        ewr = (ph == 1 || ph == 2) && (mq.size() < D) && (nr < N);
        er  = '0;
        if (erv) er = ops[ns];
        chk("rvalid", 32'(rvalid), 32'(erv));
        chk("rdata", 32'(rdata), 32'(er));
        chk("wready", 32'(wready), 32'(ewr));
        chk("busy", 32'(busy), 32'(ph == 1 || ph == 2));
        chk("done", 32'(done), 32'(ph == 3));
        chk("res_valid", 32'(res_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("res_data", 32'(res_data), 32'(mq[0]));
        else chk("res_data_idle", 32'(res_data), 32'(0));
        chk("sent_cnt", 32'(sent_cnt), 32'(ns));
        chk("recv_cnt", 32'(recv_cnt), 32'(nr));
        chk("checksum", 32'(checksum), 32'(csum));
        if (done) ndone++;
        if (first_pending && rvalid) begin
            chk("first_word", 32'(rdata), 32'h2A5);
            first_pending = 0;
        end
        if (rst_req) begin
            mreset();
        end else begin
            tx   = erv && rready;
            push = wvalid && ewr;
            pop  = (mq.size() != 0) && res_ready;
            nph  = ph;
            case (ph)
                0: if (start) nph = 1;
                1: if (ns == N) nph = 2;
                2: if (nr == N && mq.size() == 0) nph = 3;
                default: nph = 0;
            endcase
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(wdata);
                nr++;
                csum = csum ^ wdata;
                if (!force_w) void'(alu_q.pop_front());
            end
            if (tx) begin
                alu_q.push_back(ops[ns]);
                ns++;
            end
            if (ph == 0 && start) begin
                ns = 0;
                nr = 0;
                csum = '0;
            end
            ph = nph;
        end
        rst_req = 0;
        start_req = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int rrm, input bit rsr, input int hold,
                       input int abort_at, input bit spur);
        int           cyc;
        int           d0;
        bit           aborted;
        logic [W-1:0] x;
        cyc = 0;
        d0 = ndone;
        aborted = 0;
        rr_mode = rrm;
        rs_rand = rsr;
        wv_rand = rsr;
        rs_hold = hold;
        k = 0;
        first_pending = 1;
        start_req = 1;
        cycle();
        while (ph != 0 && cyc < 600) begin
            if (abort_at > 0 && !aborted && ns == abort_at) begin
                rst_req = 1;
                aborted = 1;
            end
            if (spur && cyc == 3) start_req = 1;
            if (hold >= 20 && cyc == hold - 2) begin
                chk("full_recv", 32'(recv_cnt), 32'(4));
                chk("full_wready", 32'(wready), 32'(0));
                chk("full_head", 32'(res_data), 32'(ops[0]));
            end
            cycle();
            cyc++;
        end
        chk("run_end_busy", 32'(busy), 32'(0));
        chk("done_pulses", 32'(ndone - d0), aborted ? 32'(0) : 32'(1));
        if (aborted) begin
            chk("abort_sent", 32'(sent_cnt), 32'(0));
            chk("abort_rvalid", 32'(rvalid), 32'(0));
        end else begin
            x = '0;
            for (int i = 0; i < N; i++) x = x ^ ops[i];
            chk("final_sent", 32'(sent_cnt), 32'(N));
            chk("final_recv", 32'(recv_cnt), 32'(N));
            chk("final_csum", 32'(checksum), 32'(x));
        end
    endtask

    initial begin
        ops[0] = 10'h2A5;
        for (int i = 1; i < N; i++) ops[i] = step(ops[i-1]);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mreset();
        repeat (2) cycle();

        run(0, 0, 0, 0, 0);

        force_w = 1;
        repeat (3) cycle();
        force_w = 0;
        cycle();

        run(1, 0, 0, 0, 0);
        run(0, 0, 20, 0, 0);
        run(2, 1, 0, 0, 1);
        run(0, 0, 0, 3, 0);
        run(0, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            run($urandom_range(0, 2), 1'($urandom % 2), 0, 0, 0);
            repeat (2) cycle();
        end
        run(2, 1, 0, 4, 0);
        run(2, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
